// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the CP0 interrupt arbiter: FSM encodings, default sizing
// and the CP0 register indices used for mask and cause-id readback.
package irq_arbiter_pkg;

    localparam int NSRC_DEF = 8;
    localparam int IDW_DEF  = 4;

    localparam logic [4:0] CP0_IRQ_MASK_IDX  = 5'd20;
    localparam logic [4:0] CP0_IRQ_CAUSE_IDX = 5'd21;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_arbiter_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req_i and whether any bit is set.
module prio_enc #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         vld_o
);

    // Scan high to low so the lowest set index is written last and wins.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter in front of CP0: pending latch, software mask, fixed
// priority select and request/service tracking. IRQ_EDGE_TRIGGER_EN selects edge-triggered sources.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    output logic            ir_req,
    input  logic            ir_taken,
    input  logic            eret,
    output logic [IDW-1:0]  cause_id,
    output logic            in_service,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask
);

    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q;
    logic [NSRC-1:0] set_vec, clr_vec, eligible;
    logic [IDW-1:0]  sel, cause_q, cause_d;
    logic            sel_vld;
    logic            take;
    irq_state_e      state_q, state_d;
    logic            ir_req_q, ir_req_d;
    logic            in_service_q, in_service_d;

`ifdef IRQ_EDGE_TRIGGER_EN
    // Registered sample plus previous value; a rising edge of the sample sets pending.
    logic [NSRC-1:0] src_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= '0;
            prev_q <= '0;
        end else begin
            src_q  <= irq_src;
            prev_q <= src_q;
        end
    end

    assign set_vec = src_q & ~prev_q;
`else
    assign set_vec = irq_src;
`endif

    assign take = (state_q == IRQ_REQ) && ir_taken;

    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NSRC; i++) begin
            clr_vec[i] = take && (cause_q == IDW'(i));
        end
    end

    // Set is OR-ed in after the clear so a simultaneous new assertion is never lost.
    assign pending_d = (pending_q & ~clr_vec) | set_vec;
    assign eligible  = pending_q & mask_q;

    prio_enc #(
        .N(NSRC),
        .W(IDW)
    ) u_prio_enc (
        .req_i(eligible),
        .idx_o(sel),
        .vld_o(sel_vld)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IRQ_IDLE: begin
                if (sel_vld) begin
                    state_d = IRQ_REQ;
                    cause_d = sel;
                end
            end
            IRQ_REQ: begin
                if (ir_taken) begin
                    state_d = IRQ_SERVICE;
                end else if (!sel_vld) begin
                    state_d = IRQ_IDLE;
                end else begin
                    cause_d = sel;
                end
            end
            IRQ_SERVICE: begin
                if (eret) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
        ir_req_d     = (state_d == IRQ_REQ);
        in_service_d = (state_d == IRQ_SERVICE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IRQ_IDLE;
            cause_q      <= '0;
            ir_req_q     <= 1'b0;
            in_service_q <= 1'b0;
            pending_q    <= '0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            ir_req_q     <= ir_req_d;
            in_service_q <= in_service_d;
            pending_q    <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    assign ir_req     = ir_req_q;
    assign cause_id   = cause_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule
